// File: rtl/tx_packet_arbiter.sv
// Two-requester AXI-Stream packet arbiter. Packets are granted whole, with round-robin
// choice on contention and one idle bubble cycle between packets.
module tx_packet_arbiter #(
    parameter int DW = 512,
    parameter int KW = DW / 8,
    parameter int CW = 32
) (
    input  logic          s_axis_clk,
    input  logic          s_resetn,
    input  logic          enable,

    input  logic [DW-1:0] axis0_in_tdata,
    input  logic [KW-1:0] axis0_in_tkeep,
    input  logic          axis0_in_tlast,
    input  logic          axis0_in_tvalid,
    output logic          axis0_in_tready,

    input  logic [DW-1:0] axis1_in_tdata,
    input  logic [KW-1:0] axis1_in_tkeep,
    input  logic          axis1_in_tlast,
    input  logic          axis1_in_tvalid,
    output logic          axis1_in_tready,

    output logic [DW-1:0] axis_out_tdata,
    output logic [KW-1:0] axis_out_tkeep,
    output logic          axis_out_tlast,
    output logic          axis_out_tvalid,
    input  logic          axis_out_tready,

    output logic          busy,
    output logic [CW-1:0] pkt_count0,
    output logic [CW-1:0] pkt_count1,
    output logic [1:0]    fsm_state
);

    // Handshake: a beat moves when tvalid and tready are both high at a clock edge;
    // a source may drop tvalid between beats, and tready never waits on tvalid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND0 = 2'd1,
        SEND1 = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last_grant;
    logic   done0, done1;

    assign done0 = (state == SEND0) && axis0_in_tvalid && axis_out_tready && axis0_in_tlast;
    assign done1 = (state == SEND1) && axis1_in_tvalid && axis_out_tready && axis1_in_tlast;
    assign fsm_state = state;

    always_ff @(posedge s_axis_clk) begin
        if (!s_resetn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            pkt_count0 <= '0;
            pkt_count1 <= '0;
        end else begin
            state <= state_nxt;
            if (done0) begin
                last_grant <= 1'b0;
                pkt_count0 <= pkt_count0 + {{(CW-1){1'b0}}, 1'b1};
            end
            if (done1) begin
                last_grant <= 1'b1;
                pkt_count1 <= pkt_count1 + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        axis_out_tdata  = '0;
        axis_out_tkeep  = '0;
        axis_out_tlast  = 1'b0;
        axis_out_tvalid = 1'b0;
        axis0_in_tready = 1'b0;
        axis1_in_tready = 1'b0;
        busy            = 1'b0;
        case (state)
            IDLE: begin
                // Enable only gates new grants; a packet in flight always completes.
                if (enable) begin
                    if (axis0_in_tvalid && axis1_in_tvalid)
                        state_nxt = last_grant ? SEND0 : SEND1;
                    else if (axis0_in_tvalid)
                        state_nxt = SEND0;
                    else if (axis1_in_tvalid)
                        state_nxt = SEND1;
                end
            end
            SEND0: begin
                busy            = 1'b1;
                axis_out_tdata  = axis0_in_tdata;
                axis_out_tkeep  = axis0_in_tkeep;
                axis_out_tlast  = axis0_in_tlast;
                axis_out_tvalid = axis0_in_tvalid;
                axis0_in_tready = axis_out_tready;
                if (done0) state_nxt = IDLE;
            end
            SEND1: begin
                busy            = 1'b1;
                axis_out_tdata  = axis1_in_tdata;
                axis_out_tkeep  = axis1_in_tkeep;
                axis_out_tlast  = axis1_in_tlast;
                axis_out_tvalid = axis1_in_tvalid;
                axis1_in_tready = axis_out_tready;
                if (done1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Keep the stream quiet for the whole time reset is held, before the first edge too.
        if (!s_resetn) begin
            busy            = 1'b0;
            axis_out_tvalid = 1'b0;
            axis0_in_tready = 1'b0;
            axis1_in_tready = 1'b0;
        end
    end

endmodule
